// File: rtl/serializer_pkg.sv
// Shared types and length helpers for the parametrised serializer.
package serializer_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StSend = 1'b1
  } ser_state_t;

  // A length code of zero stands for a full-width word.
  function automatic int unsigned decode_len(input int unsigned mod, input int unsigned data_w);
    return (mod == 0) ? data_w : mod;
  endfunction

  function automatic logic is_legal_len(input int unsigned len, input int unsigned min_len);
    return (len >= min_len);
  endfunction

endpackage

// File: rtl/param_serializer.sv
// Parallel-to-serial converter with programmable length, handshakes on both sides
// and gapless back-to-back operation.
module param_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MIN_LEN   = 3,
  parameter bit          MSB_FIRST = 1'b1,
  localparam int unsigned MOD_W    = $clog2(DATA_W),
  localparam int unsigned CNT_W    = $clog2(DATA_W + 1)
) (
  input  logic              clk_i,
  input  logic              srst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [MOD_W-1:0]  data_mod_i,
  input  logic              data_val_i,
  output logic              data_rdy_o,
  output logic              ser_data_o,
  output logic              ser_data_val_o,
  output logic              ser_data_last_o,
  input  logic              ser_data_rdy_i,
  output logic              busy_o
);

  ser_state_t        state_d, state_q;
  logic [DATA_W-1:0] shreg_d, shreg_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  int unsigned len;
  logic        len_legal;
  logic        accept;
  logic        bit_hs;
  logic        last_bit;
  logic        head_bit;

  assign len       = decode_len(32'(data_mod_i), DATA_W);
  assign len_legal = is_legal_len(len, MIN_LEN);

  assign head_bit = MSB_FIRST ? shreg_q[DATA_W-1] : shreg_q[0];

  assign ser_data_val_o  = (state_q == StSend);
  assign last_bit        = ser_data_val_o && (cnt_q == CNT_W'(1));
  assign ser_data_last_o = last_bit;
  assign ser_data_o      = ser_data_val_o & head_bit;
  assign busy_o          = (state_q == StSend);

  assign bit_hs = ser_data_val_o & ser_data_rdy_i;
  // Ready also on the final bit handshake so the next word follows without a gap.
  assign data_rdy_o = srst_n_i & ((state_q == StIdle) | (last_bit & ser_data_rdy_i));
  assign accept     = data_val_i & data_rdy_o;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (accept) begin
      if (len_legal) begin
        state_d = StSend;
        shreg_d = data_i;
        cnt_d   = CNT_W'(len);
      end else begin
        state_d = StIdle;
        shreg_d = '0;
        cnt_d   = '0;
      end
    end else if (bit_hs) begin
      if (last_bit) begin
        state_d = StIdle;
        shreg_d = '0;
        cnt_d   = '0;
      end else begin
        shreg_d = MSB_FIRST ? {shreg_q[DATA_W-2:0], 1'b0} : {1'b0, shreg_q[DATA_W-1:1]};
        cnt_d   = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state_q <= StIdle;
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_param_serializer.sv
// Directed self-checking bench: default MSB-first instance plus an 8-bit LSB-first instance.
module tb_param_serializer;

  logic        clk;
  logic        srst_n;

  logic [15:0] data;
  logic [3:0]  mod;
  logic        val;
  logic        rdy;
  logic        ser_data;
  logic        ser_val;
  logic        ser_last;
  logic        ser_rdy;
  logic        busy;

  logic [7:0]  l_data;
  logic [2:0]  l_mod;
  logic        l_val;
  logic        l_rdy;
  logic        l_ser_data;
  logic        l_ser_val;
  logic        l_ser_last;
  logic        l_ser_rdy;
  logic        l_busy;

  int n_checks;
  int n_errors;

  param_serializer u_dut (
    .clk_i          (clk),
    .srst_n_i       (srst_n),
    .data_i         (data),
    .data_mod_i     (mod),
    .data_val_i     (val),
    .data_rdy_o     (rdy),
    .ser_data_o     (ser_data),
    .ser_data_val_o (ser_val),
    .ser_data_last_o(ser_last),
    .ser_data_rdy_i (ser_rdy),
    .busy_o         (busy)
  );

  param_serializer #(
    .DATA_W   (8),
    .MIN_LEN  (3),
    .MSB_FIRST(1'b0)
  ) u_dut_lsb (
    .clk_i          (clk),
    .srst_n_i       (srst_n),
    .data_i         (l_data),
    .data_mod_i     (l_mod),
    .data_val_i     (l_val),
    .data_rdy_o     (l_rdy),
    .ser_data_o     (l_ser_data),
    .ser_data_val_o (l_ser_val),
    .ser_data_last_o(l_ser_last),
    .ser_data_rdy_i (l_ser_rdy),
    .busy_o         (l_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // seq[n-1] is the first expected bit on the line.
  task automatic expect_bits(input string tag, input logic [15:0] seq, input int n);
    for (int i = 0; i < n; i++) begin
      check_val({tag, "_bit"}, 32'(ser_data), 32'(seq[n-1-i]));
      check_val({tag, "_val"}, 32'(ser_val), 32'd1);
      check_val({tag, "_last"}, 32'(ser_last), (i == n - 1) ? 32'd1 : 32'd0);
      check_val({tag, "_busy"}, 32'(busy), 32'd1);
      step();
    end
  endtask

  task automatic accept_word(input logic [15:0] d, input logic [3:0] m);
    data = d;
    mod  = m;
    val  = 1'b1;
    check_val("accept_rdy", 32'(rdy), 32'd1);
    step();
    val  = 1'b0;
  endtask

  logic [7:0] lsb_seq;

  initial begin
    n_checks = 0;
    n_errors = 0;
    srst_n   = 1'b0;
    data     = '0;
    mod      = '0;
    val      = 1'b0;
    ser_rdy  = 1'b1;
    l_data   = '0;
    l_mod    = '0;
    l_val    = 1'b0;
    l_ser_rdy = 1'b1;

    // Reset state
    step();
    step();
    check_val("rst_rdy_low", 32'(rdy), 32'd0);
    check_val("rst_val", 32'(ser_val), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_last", 32'(ser_last), 32'd0);
    srst_n = 1'b1;
    #1;
    check_val("idle_rdy", 32'(rdy), 32'd1);

    // Full word; input changes after accept must be ignored
    accept_word(16'hA5C3, 4'd0);
    data = 16'h0000;
    mod  = 4'd5;
    expect_bits("full", 16'hA5C3, 16);
    check_val("full_after_val", 32'(ser_val), 32'd0);
    check_val("full_after_busy", 32'(busy), 32'd0);
    check_val("full_after_rdy", 32'(rdy), 32'd1);

    // Shortest legal length
    accept_word(16'hE000, 4'd3);
    expect_bits("short", 16'h0007, 3);
    check_val("short_after_val", 32'(ser_val), 32'd0);

    // Length below minimum is consumed and dropped
    accept_word(16'hFFFF, 4'd2);
    check_val("drop_val", 32'(ser_val), 32'd0);
    check_val("drop_busy", 32'(busy), 32'd0);
    check_val("drop_rdy", 32'(rdy), 32'd1);
    step();
    check_val("drop_val2", 32'(ser_val), 32'd0);

    // Backpressure on the third bit
    accept_word(16'h9000, 4'd4);
    check_val("bp_b1", 32'(ser_data), 32'd1);
    step();
    check_val("bp_b2", 32'(ser_data), 32'd0);
    step();
    ser_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_val("bp_hold_bit", 32'(ser_data), 32'd0);
      check_val("bp_hold_val", 32'(ser_val), 32'd1);
      check_val("bp_hold_last", 32'(ser_last), 32'd0);
      check_val("bp_hold_rdy", 32'(rdy), 32'd0);
      step();
    end
    ser_rdy = 1'b1;
    check_val("bp_b3", 32'(ser_data), 32'd0);
    check_val("bp_b3_last", 32'(ser_last), 32'd0);
    step();
    ser_rdy = 1'b0;
    #1;
    check_val("bp_b4_stall_last", 32'(ser_last), 32'd1);
    check_val("bp_b4_stall_rdy", 32'(rdy), 32'd0);
    step();
    ser_rdy = 1'b1;
    check_val("bp_b4", 32'(ser_data), 32'd1);
    check_val("bp_b4_last", 32'(ser_last), 32'd1);
    step();
    check_val("bp_done_val", 32'(ser_val), 32'd0);

    // Back-to-back: A = 0,1,0,1 then B = 1,0,1,1,1 with no gap
    accept_word(16'h5000, 4'd4);
    data = 16'hB800;
    mod  = 4'd5;
    val  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_val("b2b_a_bit", 32'(ser_data), (i == 1) ? 32'd1 : 32'd0);
      check_val("b2b_a_rdy", 32'(rdy), 32'd0);
      step();
    end
    check_val("b2b_a_last_bit", 32'(ser_data), 32'd1);
    check_val("b2b_a_last", 32'(ser_last), 32'd1);
    check_val("b2b_a_rdy_last", 32'(rdy), 32'd1);
    step();
    val = 1'b0;
    expect_bits("b2b_b", 16'h0017, 5);
    check_val("b2b_done_val", 32'(ser_val), 32'd0);

    // Reset mid-word after 5 bits
    accept_word(16'hFFFF, 4'd0);
    for (int i = 0; i < 5; i++) begin
      check_val("rmw_bit", 32'(ser_data), 32'd1);
      step();
    end
    srst_n = 1'b0;
    #1;
    check_val("rmw_rdy_in_rst", 32'(rdy), 32'd0);
    step();
    check_val("rmw_val", 32'(ser_val), 32'd0);
    check_val("rmw_last", 32'(ser_last), 32'd0);
    check_val("rmw_busy", 32'(busy), 32'd0);
    check_val("rmw_data", 32'(ser_data), 32'd0);
    srst_n = 1'b1;
    #1;
    check_val("rmw_rdy_after", 32'(rdy), 32'd1);
    accept_word(16'h3C00, 4'd8);
    expect_bits("rmw_new", 16'h003C, 8);
    check_val("rmw_new_done", 32'(ser_val), 32'd0);

    // LSB-first, 8-bit instance: 8'h2D -> 1,0,1,1,0,1,0,0
    lsb_seq = 8'b1011_0100;
    l_data  = 8'h2D;
    l_mod   = 3'd0;
    l_val   = 1'b1;
    check_val("lsb_rdy", 32'(l_rdy), 32'd1);
    step();
    l_val  = 1'b0;
    l_data = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      check_val("lsb_bit", 32'(l_ser_data), 32'(lsb_seq[7-i]));
      check_val("lsb_val", 32'(l_ser_val), 32'd1);
      check_val("lsb_last", 32'(l_ser_last), (i == 7) ? 32'd1 : 32'd0);
      step();
    end
    check_val("lsb_done_val", 32'(l_ser_val), 32'd0);
    check_val("lsb_done_busy", 32'(l_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
